// File: rtl/fpga_bpf_pkg.sv
// Shared widths, forwarder FSM state and beat helpers for the packet filter datapath.
package fpga_bpf_pkg;

    localparam int CODE_ADDR_WIDTH        = 10;
    localparam int CODE_DATA_WIDTH        = 64;
    localparam int PACKET_BYTE_ADDR_WIDTH = 12;
    localparam int PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2;
    localparam int PACKET_DATA_WIDTH      = 32;
    localparam int FWD_DATA_WIDTH         = 64;
    localparam int FWD_KEEP_WIDTH         = FWD_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        FWD_IDLE,
        FWD_FETCH,
        FWD_DRAIN,
        FWD_DONE
    } fwd_state_e;

    // Number of 64-bit beats for a (pre-clamped) byte length: ceil(len/8).
    function automatic logic [PACKET_ADDR_WIDTH-1:0] fwd_beat_count(
        input logic [PACKET_BYTE_ADDR_WIDTH:0] len_bytes
    );
        return PACKET_ADDR_WIDTH'((len_bytes + (PACKET_BYTE_ADDR_WIDTH + 1)'(7)) >> 3);
    endfunction

    function automatic logic [FWD_KEEP_WIDTH-1:0] fwd_last_keep(input logic [2:0] rem);
        return (rem == 3'd0) ? '1 : FWD_KEEP_WIDTH'((9'd1 << rem) - 9'd1);
    endfunction

endpackage

// File: rtl/packet_forwarder_if.sv
// AXI4-Stream egress bundle driven by the packet forwarder.
interface packet_forwarder_if;
    import fpga_bpf_pkg::*;

    logic [FWD_DATA_WIDTH-1:0] tdata;
    logic [FWD_KEEP_WIDTH-1:0] tkeep;
    logic                      tlast;
    logic                      tvalid;
    logic                      tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);

endinterface

// File: rtl/fwd_skid_buffer.sv
// Two-entry valid/ready buffer between the read-data return and the egress stream.
module fwd_skid_buffer #(
    parameter int WIDTH = 73
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;
    assign push     = in_valid && !full;
    assign pop      = !empty && out_ready;
    assign out_data = mem_q[rd_ptr_q];

    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // the two storage entries are reset too, so the stream reads all-zero after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/packet_forwarder.sv
// Reads an accepted packet out of packet memory as 64-bit beats and streams it on AXIS.
module packet_forwarder #(
    parameter int PACKET_BYTE_ADDR_WIDTH = fpga_bpf_pkg::PACKET_BYTE_ADDR_WIDTH,
    parameter int PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2,
    parameter int DATA_WIDTH             = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ready_for_forwarder,
    input  logic [PACKET_BYTE_ADDR_WIDTH:0] fwd_len,
    output logic [PACKET_ADDR_WIDTH-1:0]  forwarder_rd_addr,
    output logic                          forwarder_rd_en,
    input  logic [DATA_WIDTH-1:0]         forwarder_rd_data,
    output logic                          forwarder_done,
    packet_forwarder_if.master            m_axis
);
    import fpga_bpf_pkg::*;

    localparam int LEN_W  = PACKET_BYTE_ADDR_WIDTH + 1;
    localparam int BEAT_W = PACKET_ADDR_WIDTH;
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int SKID_W = DATA_WIDTH + KEEP_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {PACKET_BYTE_ADDR_WIDTH{1'b0}}};

    fwd_state_e state_q, state_d;

    logic [PACKET_ADDR_WIDTH-1:0] rd_addr_q;
    logic [BEAT_W-1:0]            beats_q;
    logic [BEAT_W-1:0]            issued_q;
    logic [KEEP_W-1:0]            last_keep_q;
    logic                         pend_q;
    logic                         pend_last_q;
    logic [KEEP_W-1:0]            pend_keep_q;

    logic [LEN_W-1:0]  len_clamped;
    logic [KEEP_W-1:0] keep_tail;
    logic [1:0]        occupancy;
    logic              pop;
    logic              issue;
    logic              issue_last;

    logic              skid_full;
    logic              skid_empty;
    logic [1:0]        skid_count;
    logic [SKID_W-1:0] skid_out;
    logic              skid_last;

    fwd_skid_buffer #(.WIDTH(SKID_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pend_q),
        .in_data   ({forwarder_rd_data, pend_keep_q, pend_last_q}),
        .out_data  (skid_out),
        .out_ready (m_axis.tready),
        .full      (skid_full),
        .empty     (skid_empty),
        .count     (skid_count)
    );

    assign skid_last     = skid_out[0];
    assign m_axis.tdata  = skid_out[SKID_W-1 -: DATA_WIDTH];
    assign m_axis.tkeep  = skid_out[KEEP_W:1];
    assign m_axis.tlast  = skid_last;
    assign m_axis.tvalid = !skid_empty;

    assign forwarder_rd_addr = rd_addr_q;
    assign forwarder_rd_en   = issue;
    assign forwarder_done    = (state_q == FWD_DONE);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        len_clamped = (fwd_len > MAX_LEN) ? MAX_LEN : fwd_len;
        keep_tail   = fwd_last_keep(len_clamped[2:0]);
        pop         = !skid_empty && m_axis.tready;
        // Occupancy after this cycle's pop, counting the read whose data lands next edge.
        occupancy   = skid_full ? (2'd2 - 2'(pop)) : (2'(pend_q) + skid_count - 2'(pop));
        issue       = (state_q == FWD_FETCH) && (occupancy < 2'd2);
        issue_last  = (issued_q == beats_q - BEAT_W'(1));

        unique case (state_q)
            FWD_IDLE: begin
                if (ready_for_forwarder) begin
                    state_d = (len_clamped == '0) ? FWD_DONE : FWD_FETCH;
                end
            end
            FWD_FETCH: begin
                if (issue && issue_last) state_d = FWD_DRAIN;
            end
            FWD_DRAIN: begin
                if (pop && skid_last) state_d = FWD_DONE;
            end
            FWD_DONE: state_d = FWD_IDLE;
            default:  state_d = FWD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= FWD_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_addr_q   <= '0;
            beats_q     <= '0;
            issued_q    <= '0;
            last_keep_q <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            pend_keep_q <= '0;
        end else begin
            pend_q <= issue;
            if (state_q == FWD_IDLE && ready_for_forwarder) begin
                rd_addr_q   <= '0;
                issued_q    <= '0;
                beats_q     <= fwd_beat_count(len_clamped);
                last_keep_q <= keep_tail;
            end
            if (issue) begin
                rd_addr_q   <= rd_addr_q + PACKET_ADDR_WIDTH'(2);
                issued_q    <= issued_q + BEAT_W'(1);
                pend_last_q <= issue_last;
                pend_keep_q <= issue_last ? last_keep_q : '1;
            end
        end
    end

endmodule

// File: tb/tb_packet_forwarder.sv
// Directed bench for packet_forwarder: memory model with tagged words, AXIS sink with stall patterns.
module tb_packet_forwarder;
    import fpga_bpf_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ready_for_forwarder = 1'b0;
    logic [12:0] fwd_len = '0;
    logic [9:0]  rd_addr;
    logic        rd_en;
    logic [63:0] rd_data = '0;
    logic        done;
    logic [7:0]  tag = 8'h00;

    int total = 0;
    int bad   = 0;

    packet_forwarder_if axis ();

    packet_forwarder dut (
        .clk                 (clk),
        .rst                 (rst),
        .ready_for_forwarder (ready_for_forwarder),
        .fwd_len             (fwd_len),
        .forwarder_rd_addr   (rd_addr),
        .forwarder_rd_en     (rd_en),
        .forwarder_rd_data   (rd_data),
        .forwarder_done      (done),
        .m_axis              (axis)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] t, input logic [9:0] a);
        return {t, 14'h0, a};
    endfunction

    // Packet memory: one-cycle read latency, word addr in [31:0], addr+1 in [63:32].
    always @(posedge clk) begin
        rd_data <= rd_en ? {mem_word(tag, rd_addr + 10'd1), mem_word(tag, rd_addr)} : 64'h0;
    end

    function automatic logic [63:0] exp_beat(input logic [7:0] t, input int i);
        logic [9:0] a;
        a = 10'(2 * i);
        return {mem_word(t, a + 10'd1), mem_word(t, a)};
    endfunction

    function automatic logic [63:0] keep_mask(input logic [7:0] k);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_rd_en"},   64'(rd_en),        64'h0);
        check({phase, "_done"},    64'(done),         64'h0);
        check({phase, "_tvalid"},  64'(axis.tvalid),  64'h0);
        check({phase, "_tlast"},   64'(axis.tlast),   64'h0);
        check({phase, "_tkeep"},   64'(axis.tkeep),   64'h0);
        check({phase, "_tdata"},   axis.tdata,        64'h0);
        check({phase, "_rd_addr"}, 64'(rd_addr),      64'h0);
    endtask

    task automatic run_packet(input logic [7:0] t, input int len, input int exp_beats,
                              input logic [7:0] exp_last_keep, input bit toggle,
                              input bit best_case, input bit hold_ready);
        int          issued = 0;
        int          accepted = 0;
        int          first_valid = -1;
        int          last_hs = -1;
        bit          finished = 0;
        bit          stalled = 0;
        logic [63:0] held_data = '0;
        logic [7:0]  held_keep = '0;
        logic        held_last = 1'b0;
        logic [7:0]  exp_keep;
        logic [63:0] mask;
        logic        is_last;

        @(negedge clk);
        tag = t;
        ready_for_forwarder = 1'b1;
        fwd_len = 13'(len);
        axis.tready = 1'b1;
        #1;
        check("idle_done_low", 64'(done), 64'h0);
        check("idle_tvalid_low", 64'(axis.tvalid), 64'h0);

        for (int cyc = 1; cyc <= exp_beats * 4 + 20 && !finished; cyc++) begin
            @(negedge clk);
            axis.tready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            if (stalled) begin
                check("stall_tvalid", 64'(axis.tvalid), 64'h1);
                check("stall_tdata", axis.tdata, held_data);
                check("stall_tkeep", 64'(axis.tkeep), 64'(held_keep));
                check("stall_tlast", 64'(axis.tlast), 64'(held_last));
            end
            if (rd_en) begin
                check("rd_addr", 64'(rd_addr), 64'(2 * issued));
                issued++;
                check("read_count", 64'(issued <= exp_beats), 64'h1);
            end
            if (axis.tvalid && first_valid < 0) first_valid = cyc;
            if (axis.tvalid && axis.tready) begin
                is_last  = (accepted == exp_beats - 1);
                exp_keep = is_last ? exp_last_keep : 8'hFF;
                mask     = keep_mask(exp_keep);
                check("tdata", axis.tdata & mask, exp_beat(t, accepted) & mask);
                check("tkeep", 64'(axis.tkeep), 64'(exp_keep));
                check("tlast", 64'(axis.tlast), 64'(is_last));
                accepted++;
                last_hs = cyc;
            end
            if (rd_en) check("outstanding", 64'((issued - accepted) <= 2), 64'h1);
            stalled   = axis.tvalid && !axis.tready;
            held_data = axis.tdata;
            held_keep = axis.tkeep;
            held_last = axis.tlast;
            if (done) begin
                finished = 1;
                check("beat_total", 64'(accepted), 64'(exp_beats));
                if (exp_beats > 0) check("done_latency", 64'(cyc - last_hs), 64'h1);
                else               check("empty_done_latency", 64'(cyc <= 2), 64'h1);
                if (!hold_ready) ready_for_forwarder = 1'b0;
            end
        end
        check("finished", 64'(finished), 64'h1);
        if (best_case) check("first_valid_latency", 64'(first_valid), 64'd3);
    endtask

    initial begin
        int accepted;

        axis.tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        run_packet(8'h11, 24,   3,   8'hFF, 1'b0, 1'b1, 1'b0);
        run_packet(8'h22, 13,   2,   8'h1F, 1'b0, 1'b0, 1'b0);
        run_packet(8'h33, 0,    0,   8'hFF, 1'b0, 1'b0, 1'b0);
        run_packet(8'h44, 64,   8,   8'hFF, 1'b1, 1'b0, 1'b0);
        run_packet(8'h55, 4096, 512, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_packet(8'h5A, 5000, 512, 8'hFF, 1'b0, 1'b0, 1'b0);

        // Reset lands on the edge that accepts beat 3 of an 8-beat packet.
        @(negedge clk);
        tag = 8'hA6;
        ready_for_forwarder = 1'b1;
        fwd_len = 13'd64;
        axis.tready = 1'b1;
        accepted = 0;
        for (int c = 0; c < 40 && accepted < 3; c++) begin
            @(negedge clk);
            #1;
            if (axis.tvalid && axis.tready) accepted++;
        end
        check("rst_reach_beat3", 64'(accepted), 64'd3);
        rst = 1'b0;
        ready_for_forwarder = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("mid_rst");
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("post_rst_no_done", 64'(done), 64'h0);
            check("post_rst_no_tvalid", 64'(axis.tvalid), 64'h0);
        end
        run_packet(8'h77, 20, 3, 8'h0F, 1'b0, 1'b0, 1'b0);

        // Back-to-back: ready stays high across the done pulse.
        run_packet(8'h81, 13, 2, 8'h1F, 1'b0, 1'b0, 1'b1);
        run_packet(8'h92, 24, 3, 8'hFF, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_forwarder.md
Name: packet_forwarder

Overview:
- Consumer end of the packet memory's forwarder interface.
- When the memory signals an accepted packet, the block reads it out as 64-bit beats and streams them on an AXI4-Stream master.
- It pulses forwarder_done after the last beat is accepted, which returns the buffer to the snooper/CPU ping-pong.
- Sits beside the filter VM, between packet memory and the egress stream.

Parameters:
PACKET_BYTE_ADDR_WIDTH, 12, byte address width of packet memory (max packet 2^12 bytes)
PACKET_ADDR_WIDTH, PACKET_BYTE_ADDR_WIDTH-2, 32-bit word address width of forwarder_rd_addr
DATA_WIDTH, 64, forwarder read data and stream width (fixed at 64)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
ready_for_forwarder  in  1  packet memory holds an accepted packet for us
fwd_len  in  PACKET_BYTE_ADDR_WIDTH+1  packet length in bytes; valid while ready_for_forwarder=1
forwarder_rd_addr  out  PACKET_ADDR_WIDTH  32-bit word address; each read returns words addr and addr+1
forwarder_rd_en  out  1  read strobe
forwarder_rd_data  in  64  read data, valid exactly 1 cycle after rd_en; byte 0 of the beat in [7:0]
forwarder_done  out  1  1-cycle pulse: packet fully sent
m_axis_tdata  out  64  stream data
m_axis_tkeep  out  8  byte enables
m_axis_tlast  out  1  last beat of packet
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE.
  - All outputs 0: rd_en, done, tvalid, tlast, tkeep, tdata, rd_addr.
  - Skid buffer emptied; any in-flight read data is discarded.
- Reset mid-packet: no done pulse. The packet remains owned by packet memory.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE, when ready_for_forwarder=1:
  - Latch len = min(fwd_len, 2^PACKET_BYTE_ADDR_WIDTH).
  - beats = ceil(len/8); clear the word address.
  - If len=0, go to DONE (no beats emitted). Otherwise go to FETCH.
- FETCH:
  - Issue rd_en when (in-flight reads + skid occupancy) < 2.
  - Each read advances rd_addr by 2 (word address; the low bit is always 0).
  - After issuing the beats-th read, go to DRAIN.
- DRAIN: wait until the skid buffer is empty and its last beat has been handshaken (tvalid&tready with tlast), then go to DONE.
- DONE: forwarder_done=1 for exactly one cycle, then IDLE.
  - ready_for_forwarder is not sampled again until back in IDLE.
  - The memory drops ready_for_forwarder after done.
- Read latency:
  - Data returned 1 cycle after rd_en is written into the skid buffer together with its tlast/tkeep tags.
  - Best case: first tvalid 2 cycles after ready_for_forwarder is sampled.
  - Sustained throughput is 1 beat/cycle with tready held high.
- Skid buffer is 2 entries. The credit rule above guarantees it never overflows. tready=0 stalls reads within 1 cycle.
- AXIS rules:
  - Once tvalid=1, tdata/tkeep/tlast stay stable until tready=1.
  - tvalid never depends combinationally on tready.
- tkeep:
  - All beats except the last: 8'hFF.
  - Last beat: r = len mod 8; r=0 gives 8'hFF, otherwise (1<<r)-1.
  - tdata bytes with tkeep=0 are don't-care.
- tlast is asserted only on beat index beats-1.
- Max length 4096 bytes gives 512 beats. The address wraps to 0 after the final read; the wrap is unused.
- If ready_for_forwarder deasserts mid-packet: ignored, the transfer completes.

Decomposition:
- Shared package fpga_bpf_pkg holds:
  - the width constants (CODE_ADDR_WIDTH, CODE_DATA_WIDTH, PACKET_BYTE_ADDR_WIDTH, PACKET_ADDR_WIDTH, PACKET_DATA_WIDTH);
  - the forwarder FSM state enum;
  - the beat-count and tkeep helper functions.
- One sub-module, fwd_skid_buffer:
  - 2-entry valid/ready buffer, 64+8+1 bits wide;
  - full/empty/count outputs used by the credit logic.

Test Plan:
- len=24, tready=1 -> 3 beats, rd_addr 0,2,4; tkeep FF,FF,FF; tlast on beat 3; done 1 cycle after beat 3 handshake.
- len=13 -> 2 beats, last tkeep=8'h1F, tlast on beat 2; len=0 -> no tvalid, done pulse within 2 cycles of ready.
- len=64, tready toggling 1-0-0-1 every cycle -> all 8 beats in order and none duplicated; tdata stable while stalled; at most 2 reads outstanding.
- len=4096 -> 512 beats, last rd_addr=1022, tlast on beat 512; fwd_len=5000 -> clamped to 512 beats.
- rst=0 asserted at beat 3 of 8 -> next cycle all outputs 0, no done pulse; a new packet afterwards streams correctly from addr 0.
- Back-to-back packets (ready re-asserted the cycle after done) -> second packet starts at addr 0, with no beat mixing between packets.
